// File: rtl/window_frame_engine.sv
// ---------------------------------------------------------------------------
// window_frame_engine
//
// Multi-channel windowing front end. Every accepted sample beat is multiplied,
// channel by channel, by the window coefficient for its position in the frame.
// The product is rounded half up, shifted down and saturated. The result goes
// out three cycles later with its frame index and a last flag. Coefficients
// live in a two-bank RAM. A frame always reads one bank, chosen on its
// index-0 beat, so the other bank can be reloaded while a frame is running.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   frame_restart   pulse: the next accepted sample becomes index 0
//   s_valid/s_data  sample beat, channel k at [k*DATA_W +: DATA_W]
//   bank_sel        requested bank, taken only on an index-0 beat
//   coef_wr_*       coefficient write port (bank, address, value)
//   err_clr         clears the sticky write-rejected flag
//   m_valid/m_data  windowed output beat, channel k at [k*OUT_W +: OUT_W]
//   m_last/m_index  frame position of the output beat
//   active_bank     bank used by the current frame
//   coef_wr_err     sticky flag: a write to the active bank mid-frame was dropped
//   frame_cnt       number of m_last beats emitted, wraps at 16 bits
// ---------------------------------------------------------------------------
module window_frame_engine #(
    parameter int NUM_CH    = 2,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 18,
    parameter int OUT_W     = 24,
    parameter int SHIFT     = 17,
    parameter int FRAME_LEN = 256,
    localparam int ADDR_W   = $clog2(FRAME_LEN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_restart,
    input  logic                     s_valid,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic                     bank_sel,
    input  logic                     coef_wr_en,
    input  logic                     coef_wr_bank,
    input  logic [ADDR_W-1:0]        coef_wr_addr,
    input  logic [COEF_W-1:0]        coef_wr_data,
    input  logic                     err_clr,
    output logic                     m_valid,
    output logic [NUM_CH*OUT_W-1:0]  m_data,
    output logic                     m_last,
    output logic [ADDR_W-1:0]        m_index,
    output logic                     active_bank,
    output logic                     coef_wr_err,
    output logic [15:0]              frame_cnt
);

    localparam int PW = DATA_W + COEF_W + 1;
    localparam int SW = PW + 1;
    localparam logic signed [SW-1:0] ROUND   = SW'(1) <<< (SHIFT - 1);
    localparam logic signed [SW-1:0] SAT_MAX = SW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W-1:0]        cur_idx;
    logic                     rd_bank;
    logic                     wr_accept;
    logic                     wr_reject;
    logic [COEF_W-1:0]        coef_mem [2*FRAME_LEN];
    logic [COEF_W-1:0]        s1_coef;
    logic                     s1_valid;
    logic                     s1_last;
    logic [ADDR_W-1:0]        s1_index;
    logic [NUM_CH*DATA_W-1:0] s1_data;
    logic signed [PW-1:0]     s2_prod [NUM_CH];
    logic                     s2_valid;
    logic                     s2_last;
    logic [ADDR_W-1:0]        s2_index;
    logic signed [SW-1:0]     rnd [NUM_CH];
    logic [NUM_CH*OUT_W-1:0]  sat_data;

    // The index of the beat on the inputs this cycle: a restart pulse turns
    // the current beat into index 0. The index-0 beat already reads from the
    // newly requested bank, every other beat reads the latched frame bank.
    // A write is safe when it targets the bank no frame is reading, or when
    // the engine sits idle at a frame boundary.
    always_comb begin
        cur_idx   = frame_restart ? '0 : idx;
        rd_bank   = (cur_idx == '0) ? bank_sel : active_bank;
        wr_accept = (coef_wr_bank != active_bank) || ((idx == '0) && !s_valid);
        wr_reject = coef_wr_en && !wr_accept;
    end

    // Coefficient RAM, both banks in one array with the bank as the top
    // address bit. The read is synchronous and forms the first pipeline
    // stage. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (coef_wr_en && wr_accept) begin
            coef_mem[{coef_wr_bank, coef_wr_addr}] <= coef_wr_data;
        end
        s1_coef <= coef_mem[{rd_bank, cur_idx}];
    end

    // Frame position, bank latch and sticky write error. A new rejection
    // wins over a simultaneous clear so that no error is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx         <= '0;
            active_bank <= 1'b0;
            coef_wr_err <= 1'b0;
        end else begin
            if (s_valid) begin
                idx <= cur_idx + ADDR_W'(1);
            end else if (frame_restart) begin
                idx <= '0;
            end
            if (s_valid && (cur_idx == '0)) begin
                active_bank <= bank_sel;
            end
            coef_wr_err <= wr_reject | (coef_wr_err & ~err_clr);
        end
    end

    // Stage 1 registers the samples and frame position alongside the RAM
    // read. The last flag is qualified by s_valid so that idle cycles and
    // restarts can never create one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_index <= '0;
            s1_data  <= '0;
        end else begin
            s1_valid <= s_valid;
            s1_last  <= s_valid && (cur_idx == {ADDR_W{1'b1}});
            if (s_valid) begin
                s1_index <= cur_idx;
                s1_data  <= s_data;
            end
        end
    end

    // Stage 2 forms the full-precision signed product for each channel. The
    // coefficient gets a zero sign bit so it is treated as unsigned Q1 data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_index <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                s2_prod[k] <= '0;
            end
        end else begin
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            if (s1_valid) begin
                s2_index <= s1_index;
                for (int k = 0; k < NUM_CH; k++) begin
                    s2_prod[k] <= $signed(s1_data[k*DATA_W +: DATA_W]) * $signed({1'b0, s1_coef});
                end
            end
        end
    end

    // Round half up and scale down. The sum is one bit wider than the
    // product, so adding the rounding constant can never overflow. The
    // result is then clamped to the output range.
    always_comb begin
        sat_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            rnd[k] = ($signed({s2_prod[k][PW-1], s2_prod[k]}) + ROUND) >>> SHIFT;
            if (rnd[k] > SAT_MAX) begin
                sat_data[k*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
            end else if (rnd[k] < SAT_MIN) begin
                sat_data[k*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
            end else begin
                sat_data[k*OUT_W +: OUT_W] = rnd[k][OUT_W-1:0];
            end
        end
    end

    // Stage 3 is the registered output. frame_cnt counts the last beats as
    // they leave the engine.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            m_index   <= '0;
            m_data    <= '0;
            frame_cnt <= '0;
        end else begin
            m_valid <= s2_valid;
            m_last  <= s2_last;
            if (s2_valid) begin
                m_index <= s2_index;
                m_data  <= sat_data;
            end
            if (m_valid && m_last) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_window_frame_engine.sv
// ---------------------------------------------------------------------------
// tb_window_frame_engine
//
// Bench for window_frame_engine. The main instance uses the default
// parameters. A second, small instance (OUT_W=16, SHIFT=1, FRAME_LEN=4)
// exercises output saturation.
// The stimulus tasks keep a behavioural model of the engine: a coefficient
// table per bank, the frame position and the bank in use. For every beat the
// model pushes the expected output onto a queue, and a monitor on the
// falling edge pops and compares whenever the engine presents data.
// ---------------------------------------------------------------------------
module tb_window_frame_engine;

    typedef struct {
        longint d0;
        longint d1;
        int     index;
        bit     last;
        int     due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_restart = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        bank_sel = 1'b0;
    logic        coef_wr_en = 1'b0;
    logic        coef_wr_bank = 1'b0;
    logic [7:0]  coef_wr_addr = '0;
    logic [17:0] coef_wr_data = '0;
    logic        err_clr = 1'b0;
    logic        m_valid;
    logic [47:0] m_data;
    logic        m_last;
    logic [7:0]  m_index;
    logic        active_bank;
    logic        coef_wr_err;
    logic [15:0] frame_cnt;

    logic        t_restart = 1'b0;
    logic        t_valid = 1'b0;
    logic [15:0] t_data = '0;
    logic        t_bank_sel = 1'b0;
    logic        t_wr_en = 1'b0;
    logic        t_wr_bank = 1'b0;
    logic [1:0]  t_wr_addr = '0;
    logic [17:0] t_wr_data = '0;
    logic        t_err_clr = 1'b0;
    logic        t_m_valid;
    logic [15:0] t_m_data;
    logic        t_m_last;
    logic [1:0]  t_m_index;
    logic        t_active_bank;
    logic        t_err;
    logic [15:0] t_frame_cnt;

    int          passCnt = 0;
    int          totalCnt = 0;
    int          cyc = 0;
    int          mIdx = 0;
    bit          mBank = 1'b0;
    bit          mErr = 1'b0;
    int          mFrames = 0;
    longint      coefModel [2][256];
    exp_t        sbq [$];
    exp_t        tq [$];

    window_frame_engine #(
        .NUM_CH(2), .DATA_W(16), .COEF_W(18), .OUT_W(24), .SHIFT(17), .FRAME_LEN(256)
    ) dut (
        .clk(clk), .rst(rst), .frame_restart(frame_restart), .s_valid(s_valid),
        .s_data(s_data), .bank_sel(bank_sel), .coef_wr_en(coef_wr_en),
        .coef_wr_bank(coef_wr_bank), .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data), .err_clr(err_clr), .m_valid(m_valid),
        .m_data(m_data), .m_last(m_last), .m_index(m_index),
        .active_bank(active_bank), .coef_wr_err(coef_wr_err), .frame_cnt(frame_cnt)
    );

    window_frame_engine #(
        .NUM_CH(1), .DATA_W(16), .COEF_W(18), .OUT_W(16), .SHIFT(1), .FRAME_LEN(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .frame_restart(t_restart), .s_valid(t_valid),
        .s_data(t_data), .bank_sel(t_bank_sel), .coef_wr_en(t_wr_en),
        .coef_wr_bank(t_wr_bank), .coef_wr_addr(t_wr_addr),
        .coef_wr_data(t_wr_data), .err_clr(t_err_clr), .m_valid(t_m_valid),
        .m_data(t_m_data), .m_last(t_m_last), .m_index(t_m_index),
        .active_bank(t_active_bank), .coef_wr_err(t_err), .frame_cnt(t_frame_cnt)
    );

    // Free-running clock and a count of rising edges, used for latency.
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Runaway guard so that the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: run did not finish, checks so far %0d/%0d", passCnt, totalCnt);
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input longint act, input longint req);
        totalCnt++;
        if (act == req) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Window arithmetic written directly from the number format: full
    // product, add half an LSB, floor-divide by 2^sh, clamp to the output range.
    function automatic longint modelOut(input longint s, input longint c, input int sh, input int ow);
        longint p;
        longint r;
        longint hi;
        longint lo;
        p  = s * c;
        r  = (p + (64'sd1 <<< (sh - 1))) >>> sh;
        hi = (64'sd1 <<< (ow - 1)) - 1;
        lo = -(64'sd1 <<< (ow - 1));
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    // Advance the main engine by one clock. The model first works out, from
    // the inputs now on the pins, what this edge does. Then the edge is taken
    // and the registered status flags are compared against the model.
    task automatic tick();
        int   cur;
        int   rb;
        bit   acc;
        exp_t e;
        cur = frame_restart ? 0 : mIdx;
        acc = (coef_wr_bank != mBank) || (mIdx == 0 && !s_valid);
        if (s_valid) begin
            rb      = (cur == 0) ? int'(bank_sel) : int'(mBank);
            e.d0    = modelOut(longint'($signed(s_data[15:0])), coefModel[rb][cur], 17, 24);
            e.d1    = modelOut(longint'($signed(s_data[31:16])), coefModel[rb][cur], 17, 24);
            e.index = cur;
            e.last  = (cur == 255);
            e.due   = cyc + 3;
            sbq.push_back(e);
            if (e.last) mFrames++;
        end
        if (coef_wr_en && acc) coefModel[int'(coef_wr_bank)][int'(coef_wr_addr)] = longint'(coef_wr_data);
        if (coef_wr_en && !acc) mErr = 1'b1;
        else if (err_clr) mErr = 1'b0;
        if (s_valid && cur == 0) mBank = bank_sel;
        if (s_valid) mIdx = (cur + 1) % 256;
        else if (frame_restart) mIdx = 0;
        @(posedge clk);
        #1;
        checkOutput("active_bank", longint'(active_bank), longint'(mBank));
        checkOutput("coef_wr_err", longint'(coef_wr_err), longint'(mErr));
        s_valid       = 1'b0;
        frame_restart = 1'b0;
        coef_wr_en    = 1'b0;
        err_clr       = 1'b0;
    endtask

    // One sample beat on both channels.
    task automatic applyStimulus(input int d0, input int d1, input bit bs, input bit restart);
        s_valid       = 1'b1;
        s_data        = {d1[15:0], d0[15:0]};
        bank_sel      = bs;
        frame_restart = restart;
        tick();
    endtask

    task automatic writeCoef(input bit b, input int a, input int d, input bit clr);
        coef_wr_en   = 1'b1;
        coef_wr_bank = b;
        coef_wr_addr = a[7:0];
        coef_wr_data = d[17:0];
        err_clr      = clr;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    function automatic int rndSample();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    // Let the pipeline empty, then compare the frame counter and check
    // that no expected beat was left over.
    task automatic drainCheck(input string tag);
        idle(6);
        checkOutput({tag, "_frame_cnt"}, longint'(frame_cnt), longint'(mFrames % 65536));
        checkOutput({tag, "_pending"}, longint'(sbq.size()), 0);
    endtask

    // Asynchronous reset applied mid-cycle: outputs must clear at once,
    // before any clock edge. Beats still in flight are lost.
    task automatic resetDut();
        rst = 1'b1;
        #1;
        checkOutput("rst_m_valid", longint'(m_valid), 0);
        checkOutput("rst_m_data", longint'(m_data), 0);
        checkOutput("rst_m_last", longint'(m_last), 0);
        checkOutput("rst_m_index", longint'(m_index), 0);
        checkOutput("rst_active_bank", longint'(active_bank), 0);
        checkOutput("rst_coef_wr_err", longint'(coef_wr_err), 0);
        checkOutput("rst_frame_cnt", longint'(frame_cnt), 0);
        mIdx    = 0;
        mBank   = 1'b0;
        mErr    = 1'b0;
        mFrames = 0;
        sbq.delete();
        tq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Scoreboard monitor for the main engine: every output beat is matched
    // against the oldest expected beat, including its arrival cycle. A beat
    // that is overdue without m_valid counts as missing.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_valid) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_m_valid", longint'(m_valid), 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checkOutput("ch0", longint'($signed(m_data[23:0])), e.d0);
                    checkOutput("ch1", longint'($signed(m_data[47:24])), e.d1);
                    checkOutput("m_index", longint'(m_index), longint'(e.index));
                    checkOutput("m_last", longint'(m_last), longint'(e.last));
                    checkOutput("latency", longint'(cyc), longint'(e.due));
                end
            end else if (sbq.size() > 0 && sbq[0].due < cyc) begin
                checkOutput("missing_m_valid", longint'(m_valid), 1);
                void'(sbq.pop_front());
            end else begin
                checkOutput("idle_m_last", longint'(m_last), 0);
            end
        end
    end

    // Scoreboard monitor for the saturation instance.
    always @(negedge clk) begin
        if (!rst && t_m_valid) begin
            if (tq.size() == 0) begin
                checkOutput("sat_unexpected_valid", longint'(t_m_valid), 0);
            end else begin
                exp_t e;
                e = tq.pop_front();
                checkOutput("sat_data", longint'($signed(t_m_data)), e.d0);
                checkOutput("sat_index", longint'(t_m_index), longint'(e.index));
                checkOutput("sat_latency", longint'(cyc), longint'(e.due));
            end
        end
    end

    initial begin
        int satCoef [4];
        int satSamp [4];
        int beats;
        satCoef = '{131071, 131071, 1, 1};
        satSamp = '{-32768, 32767, 3, -3};

        @(posedge clk);
        #1;
        resetDut();

        // Saturation instance: load bank 0 while idle, then one frame.
        for (int i = 0; i < 4; i++) begin
            t_wr_en   = 1'b1;
            t_wr_bank = 1'b0;
            t_wr_addr = 2'(i);
            t_wr_data = 18'(satCoef[i]);
            tick();
        end
        t_wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            t_valid = 1'b1;
            t_data  = 16'(satSamp[i]);
            e.d0    = modelOut(longint'(satSamp[i]), longint'(satCoef[i]), 1, 16);
            e.d1    = 0;
            e.index = i;
            e.last  = (i == 3);
            e.due   = cyc + 3;
            tq.push_back(e);
            tick();
        end
        t_valid = 1'b0;
        idle(5);
        checkOutput("sat_frame_cnt", longint'(t_frame_cnt), 1);
        checkOutput("sat_pending", longint'(tq.size()), 0);

        // Unity window on bank 0, constant +1000/-1000 frame.
        for (int i = 0; i < 256; i++) writeCoef(1'b0, i, 131072, 1'b0);
        for (int i = 0; i < 256; i++) applyStimulus(1000, -1000, 1'b0, 1'b0);
        drainCheck("frameA");

        // Ramp window on bank 1. A mid-frame request for bank 1 is ignored
        // until the next frame, which then runs entirely on bank 1.
        for (int i = 0; i < 256; i++) writeCoef(1'b1, i, i, 1'b0);
        for (int i = 0; i < 256; i++) applyStimulus(rndSample(), rndSample(), (i >= 100), 1'b0);
        for (int i = 0; i < 256; i++) applyStimulus(32767, rndSample(), 1'b1, 1'b0);
        drainCheck("frameC");

        // Near-unity window on bank 0: rounding up and the negative corner.
        for (int i = 0; i < 256; i++) writeCoef(1'b0, i, 131071, 1'b0);
        for (int i = 0; i < 256; i++) applyStimulus(32767, -32768, 1'b0, 1'b0);
        drainCheck("frameD");

        // Write protection of the active bank and the sticky error flag.
        for (int i = 0; i < 10; i++) applyStimulus(rndSample(), rndSample(), 1'b0, 1'b0);
        writeCoef(1'b0, 5, 7, 1'b0);
        err_clr = 1'b1;
        tick();
        writeCoef(1'b0, 6, 9, 1'b1);
        err_clr = 1'b1;
        tick();
        writeCoef(1'b1, 3, 12345, 1'b0);

        // Restart at index 37: that beat becomes index 0, the aborted frame
        // produces no last flag and the new frame ends 255 beats later.
        for (int i = 10; i < 37; i++) applyStimulus(rndSample(), rndSample(), 1'b0, 1'b0);
        applyStimulus(rndSample(), rndSample(), 1'b0, 1'b1);
        for (int i = 0; i < 255; i++) applyStimulus(rndSample(), rndSample(), 1'b0, 1'b0);
        drainCheck("restart");

        // An idle frame boundary allows writing the active bank.
        writeCoef(1'b0, 5, 99999, 1'b0);

        // Four frames with random gaps, random bank requests and random
        // coefficient writes (some rejected) on the gap cycles.
        beats = 0;
        while (beats < 1024) begin
            if ($urandom_range(1) == 1) begin
                applyStimulus(rndSample(), rndSample(), 1'($urandom_range(1)), 1'b0);
                beats++;
            end else begin
                if ($urandom_range(9) < 3) begin
                    coef_wr_en   = 1'b1;
                    coef_wr_bank = 1'($urandom_range(1));
                    coef_wr_addr = 8'($urandom_range(255));
                    coef_wr_data = 18'($urandom_range(262143));
                end
                err_clr = ($urandom_range(3) == 0);
                tick();
            end
        end
        drainCheck("random");

        // Reset in the middle of a frame, then restart cleanly on bank 0.
        for (int i = 0; i < 50; i++) applyStimulus(rndSample(), rndSample(), 1'b0, 1'b0);
        resetDut();
        for (int i = 0; i < 3; i++) applyStimulus(rndSample(), rndSample(), 1'b0, 1'b0);
        drainCheck("after_reset");

        $display("[TB] %0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
